// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC serial frame reader.
package adc_pkg;

  localparam int DATA_W_DEF     = 12;
  localparam int LEAD_ZEROS_DEF = 4;
  localparam int FRAME_BITS_DEF = DATA_W_DEF + LEAD_ZEROS_DEF;
  localparam int CNT_W          = $clog2(FRAME_BITS_DEF + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with optional one-clk rise/fall pulse generation.
module sync_edge_det #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Metastability chain for the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic prev_d;

      always_comb begin
        prev_d = sync_q[1];
      end

      // Previous synchronised level, for edge comparison.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= prev_d;
        end
      end

      assign rise = sync_q[1] & ~prev_q;
      assign fall = ~sync_q[1] & prev_q;
    end else begin : g_level_only
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/adc_frame_reader.sv
// Frames the two-channel serial ADC, shifts in one word per conversion and keeps the last sample per channel.
// Optional leading-zero check enabled with `define ADC_FRAME_CHK_EN (adds frame_err).
module adc_frame_reader
  import adc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
  parameter int GAP_EDGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_clk,
  input  logic              add_a,
  input  logic              sdata,
  input  logic              enable,
  output logic              cs_n,
  output logic              ch_sel,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              valid,
  output logic              chan,
`ifdef ADC_FRAME_CHK_EN
  output logic              frame_err,
`endif
  output logic              busy
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
  localparam int BCNT_W     = cnt_width(FRAME_BITS);
  localparam int GCNT_W     = cnt_width(GAP_EDGES);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_BITS - 1);
  localparam logic [GCNT_W-1:0] LAST_GAP = GCNT_W'(GAP_EDGES - 1);

  logic adc_rise_s;
  logic adc_fall_s;
  logic adc_lvl_s;
  logic sdata_s;

  sync_edge_det #(.EDGE_EN(1'b1)) u_adc_clk_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (adc_clk),
    .q     (adc_lvl_s),
    .rise  (adc_rise_s),
    .fall  (adc_fall_s)
  );

  sync_edge_det #(.EDGE_EN(1'b0)) u_sdata_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (sdata),
    .q     (sdata_s),
    .rise  (),
    .fall  ()
  );

  state_e                state_q, state_d;
  logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GCNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] shift_nxt_s;
  logic                  cs_n_q, cs_n_d;
  logic                  ch_sel_q, ch_sel_d;
  logic [DATA_W-1:0]     data_a_q, data_a_d;
  logic [DATA_W-1:0]     data_b_q, data_b_d;
  logic                  valid_q, valid_d;
  logic                  chan_q, chan_d;
  logic                  busy_q, busy_d;
  logic                  store_s;
`ifdef ADC_FRAME_CHK_EN
  logic                  frame_err_q, frame_err_d;
`endif

  // Sample store is issued on the capture of the last bit so valid and data appear together in DONE.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shift_d     = shift_q;
    cs_n_d      = cs_n_q;
    ch_sel_d    = ch_sel_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    valid_d     = 1'b0;
    chan_d      = chan_q;
    store_s     = 1'b0;
    shift_nxt_s = {shift_q[FRAME_BITS-2:0], sdata_s};
`ifdef ADC_FRAME_CHK_EN
    frame_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        if (adc_rise_s && enable) begin
          ch_sel_d = add_a;
          state_d  = START;
        end else begin
          state_d  = IDLE;
        end
      end
      START: begin
        if (adc_fall_s) begin
          cs_n_d    = 1'b0;
          bit_cnt_d = {BCNT_W{1'b0}};
          state_d   = SHIFT;
        end else begin
          state_d   = START;
        end
      end
      SHIFT: begin
        if (adc_rise_s) begin
          shift_d   = shift_nxt_s;
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
`ifdef ADC_FRAME_CHK_EN
            if (|shift_nxt_s[FRAME_BITS-1:DATA_W]) begin
              frame_err_d = 1'b1;
            end else begin
              store_s = 1'b1;
            end
`else
            store_s = 1'b1;
`endif
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        cs_n_d    = 1'b1;
        gap_cnt_d = {GCNT_W{1'b0}};
        state_d   = GAP;
      end
      GAP: begin
        if (adc_rise_s) begin
          if (gap_cnt_q == LAST_GAP) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GCNT_W'(1);
          end
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase

    if (store_s) begin
      valid_d = 1'b1;
      chan_d  = ch_sel_q;
      if (ch_sel_q) begin
        data_b_d = shift_nxt_s[DATA_W-1:0];
      end else begin
        data_a_d = shift_nxt_s[DATA_W-1:0];
      end
    end else begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= {BCNT_W{1'b0}};
      gap_cnt_q   <= {GCNT_W{1'b0}};
      shift_q     <= {FRAME_BITS{1'b0}};
      cs_n_q      <= 1'b1;
      ch_sel_q    <= 1'b0;
      data_a_q    <= {DATA_W{1'b0}};
      data_b_q    <= {DATA_W{1'b0}};
      valid_q     <= 1'b0;
      chan_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ADC_FRAME_CHK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shift_q     <= shift_d;
      cs_n_q      <= cs_n_d;
      ch_sel_q    <= ch_sel_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      valid_q     <= valid_d;
      chan_q      <= chan_d;
      busy_q      <= busy_d;
`ifdef ADC_FRAME_CHK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign cs_n   = cs_n_q;
  assign ch_sel = ch_sel_q;
  assign data_a = data_a_q;
  assign data_b = data_b_q;
  assign valid  = valid_q;
  assign chan   = chan_q;
  assign busy   = busy_q;
`ifdef ADC_FRAME_CHK_EN
  assign frame_err = frame_err_q;
`endif

  logic unused_lvl_s;
  assign unused_lvl_s = adc_lvl_s;

endmodule
